tybec_leaf_map_node_elastic: RTL and testbench

// Next-generation TyBEC leaf map node: joins NUM_IN operand streams and feeds an external

---
 rtl/tybec_leaf_map_node_elastic.sv | 118 +++++++++++
 tb/tb_tybec_leaf_map_node_elastic.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tybec_leaf_map_node_elastic.sv
// TyBEC leaf map node: joins NUM_IN operand streams into a fixed-latency, never-stalled
// operator core and buffers its results in a credit-tracked first-word-fall-through FIFO.
module tybec_leaf_map_node_elastic #(
   parameter int unsigned  W          = 34,
   parameter int unsigned  NUM_IN     = 1,
   parameter logic [W-1:0] CONST_Y    = 34'h13f802058,
   parameter int unsigned  LAT        = 12,
   parameter int unsigned  FIFO_DEPTH = 16
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_IN-1:0]                  ivalid,
   output logic [NUM_IN-1:0]                  iready,
   input  logic [NUM_IN*W-1:0]                in_data,
   output logic [W-1:0]                       op_x,
   output logic [W-1:0]                       op_y,
   input  logic [W-1:0]                       op_r,
   output logic                               ovalid,
   input  logic                               oready,
   output logic [W-1:0]                       out_data,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    credits
);

   localparam int unsigned   CW      = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned   AW      = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   logic              credit_ok;
   logic              fire;
   logic              push;
   logic              pop;
   logic              empty;
   logic              v0;
   logic [LAT-1:0]    vshift;
   logic [W-1:0]      y_in;
   logic [NUM_IN-1:0] peer_valid;
   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic [W-1:0]      mem [FIFO_DEPTH];

   // A slot is reserved at acceptance time, so the FIFO can never overflow.
   assign credit_ok = credits < DEPTH_C;
   assign fire      = ~rst & credit_ok & (&ivalid);

   // NOTE: every output of a combinational block gets a default before any conditional
   // assignment; a path that leaves one unassigned infers a latch.
   always_comb begin
      iready     = '0;
      peer_valid = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         peer_valid    = ivalid;
         peer_valid[i] = 1'b1;
         iready[i]     = ~rst & credit_ok & (&peer_valid);
      end
   end

   generate
      if (NUM_IN == 2) begin : g_two_streams
         assign y_in = in_data[W +: W];
      end else begin : g_one_stream
         assign y_in = CONST_Y;
      end
   endgenerate

   // NOTE: all state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_x   <= '0;
         op_y   <= '0;
         v0     <= 1'b0;
         vshift <= '0;
      end else begin
         v0     <= fire;
         vshift <= LAT'({vshift, v0});
         if (fire) begin
            op_x <= in_data[W-1:0];
            op_y <= y_in;
         end
      end
   end

   // Shifter tail lines up with op_r: LAT cycles after op_x/op_y were presented.
   assign push   = vshift[LAT-1];
   assign empty  = (wr_ptr == rd_ptr);
   assign ovalid = ~rst & ~empty;
   assign pop    = ovalid & oready;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // NOTE: the storage array has no reset; the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= op_r;
   end

   assign out_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         credits <= '0;
      end else begin
         unique case ({fire, pop})
            2'b10:   credits <= credits + CW'(1);
            2'b01:   credits <= credits - CW'(1);
            default: credits <= credits;
         endcase
      end
   end

endmodule

// File: tb/tb_tybec_leaf_map_node_elastic.sv
// Scoreboard bench: a single-stream node (LAT 12, depth 16) and a two-stream node with a
// shallow FIFO (LAT 5, depth 4), each driving a behavioural operator core.
module tb_tybec_leaf_map_node_elastic;

   localparam int unsigned  W         = 34;
   localparam logic [W-1:0] CONST_Y_A = 34'h13f802058;
   localparam int unsigned  LAT_A     = 12;
   localparam int unsigned  D_A       = 16;
   localparam int unsigned  LAT_B     = 5;
   localparam int unsigned  D_B       = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [0:0]   ivalid_a, iready_a;
   logic [W-1:0] in_a, op_x_a, op_y_a, op_r_a, out_data_a;
   logic         ovalid_a, oready_a;
   logic [4:0]   credits_a;

   logic [1:0]     ivalid_b, iready_b;
   logic [2*W-1:0] in_b;
   logic [W-1:0]   op_x_b, op_y_b, op_r_b, out_data_b;
   logic           ovalid_b, oready_b;
   logic [2:0]     credits_b;

   tybec_leaf_map_node_elastic #(
      .W(W), .NUM_IN(1), .CONST_Y(CONST_Y_A), .LAT(LAT_A), .FIFO_DEPTH(D_A)
   ) dut_a (
      .clk(clk), .rst(rst), .ivalid(ivalid_a), .iready(iready_a), .in_data(in_a),
      .op_x(op_x_a), .op_y(op_y_a), .op_r(op_r_a), .ovalid(ovalid_a), .oready(oready_a),
      .out_data(out_data_a), .credits(credits_a)
   );

   tybec_leaf_map_node_elastic #(
      .W(W), .NUM_IN(2), .CONST_Y(CONST_Y_A), .LAT(LAT_B), .FIFO_DEPTH(D_B)
   ) dut_b (
      .clk(clk), .rst(rst), .ivalid(ivalid_b), .iready(iready_b), .in_data(in_b),
      .op_x(op_x_b), .op_y(op_y_b), .op_r(op_r_b), .ovalid(ovalid_b), .oready(oready_b),
      .out_data(out_data_b), .credits(credits_b)
   );

   // Arbitrary but data-dependent operator standing in for the FP core.
   function automatic logic [W-1:0] core_f(input logic [W-1:0] x, input logic [W-1:0] y);
      return (x ^ {y[W-2:0], y[W-1]}) + (x >> 3) + W'(5);
   endfunction

   function automatic logic [W-1:0] rnd();
      return W'({$urandom, $urandom});
   endfunction

   // Behavioural cores: result appears exactly LAT cycles after the operands.
   logic [W-1:0] pipe_a [LAT_A];
   logic [W-1:0] pipe_b [LAT_B];
   always @(posedge clk) begin
      pipe_a[0] <= core_f(op_x_a, op_y_a);
      for (int i = 1; i < LAT_A; i++) pipe_a[i] <= pipe_a[i-1];
      pipe_b[0] <= core_f(op_x_b, op_y_b);
      for (int i = 1; i < LAT_B; i++) pipe_b[i] <= pipe_b[i-1];
   end
   assign op_r_a = pipe_a[LAT_A-1];
   assign op_r_b = pipe_b[LAT_B-1];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Scoreboards: queue length is the number of accepted-but-not-delivered results.
   logic [W-1:0] q_a[$], q_b[$];
   int qc_a[$], qc_b[$];
   int n_acc_a = 0, last_acc_a = 0, pop_cnt_a = 0, last_pop_a = 0, last_lat_a = 0;
   int n_acc_b = 0, pop_cnt_b = 0, max_cred_b = 0;

   always @(negedge clk) begin
      if (rst) begin
         check("rst_iready_a", iready_a, 1'b0);
         check("rst_ovalid_a", ovalid_a, 1'b0);
         q_a.delete();
         qc_a.delete();
      end else begin
         check("iready_a", iready_a, q_a.size() < D_A);
         check("credits_a", credits_a, q_a.size());
         if (ovalid_a && oready_a) begin
            if (q_a.size() == 0) begin
               check("spurious_out_a", ovalid_a, 1'b0);
            end else begin
               check("data_a", out_data_a, q_a[0]);
               check("min_latency_a", (cyc - qc_a[0]) >= LAT_A + 2, 1'b1);
               last_lat_a <= cyc - qc_a[0];
               void'(q_a.pop_front());
               void'(qc_a.pop_front());
               pop_cnt_a  <= pop_cnt_a + 1;
               last_pop_a <= cyc;
            end
         end
         if (ivalid_a[0] && iready_a[0]) begin
            q_a.push_back(core_f(in_a, CONST_Y_A));
            qc_a.push_back(cyc);
            n_acc_a    <= n_acc_a + 1;
            last_acc_a <= cyc;
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         check("rst_iready_b", iready_b, 2'b00);
         check("rst_ovalid_b", ovalid_b, 1'b0);
         q_b.delete();
         qc_b.delete();
      end else begin
         check("iready_b", iready_b,
               {(q_b.size() < D_B) & ivalid_b[0], (q_b.size() < D_B) & ivalid_b[1]});
         check("credits_b", credits_b, q_b.size());
         if (int'(credits_b) > max_cred_b) max_cred_b <= int'(credits_b);
         if (ovalid_b && oready_b) begin
            if (q_b.size() == 0) begin
               check("spurious_out_b", ovalid_b, 1'b0);
            end else begin
               check("data_b", out_data_b, q_b[0]);
               check("min_latency_b", (cyc - qc_b[0]) >= LAT_B + 2, 1'b1);
               void'(q_b.pop_front());
               void'(qc_b.pop_front());
               pop_cnt_b <= pop_cnt_b + 1;
            end
         end
         if ((&ivalid_b) && iready_b[0]) begin
            q_b.push_back(core_f(in_b[0 +: W], in_b[W +: W]));
            qc_b.push_back(cyc);
            n_acc_b <= n_acc_b + 1;
         end
      end
   end

   task automatic drain_a();
      oready_a = 1'b1;
      ivalid_a = 1'b0;
      for (int g = 0; g < 100 && q_a.size() != 0; g++) tick(1);
      check("drain_a", q_a.size(), 0);
   endtask

   task automatic drain_b();
      oready_b = 1'b1;
      ivalid_b = 2'b00;
      for (int g = 0; g < 100 && q_b.size() != 0; g++) tick(1);
      check("drain_b", q_b.size(), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int base, pbase, prev, t0;
      rst = 1'b1;
      ivalid_a = '0; in_a = '0; oready_a = 1'b0;
      ivalid_b = '0; in_b = '0; oready_b = 1'b0;
      tick(3);
      rst = 1'b0;
      @(negedge clk);
      check("reset_credits_a", credits_a, 0);
      check("reset_ovalid_a", ovalid_a, 1'b0);
      check("reset_op_x_a", op_x_a, 0);
      check("reset_op_y_a", op_y_a, 0);
      check("reset_credits_b", credits_b, 0);

      // T1: single 1.0 operand, constant second operand, exact latency LAT+2.
      tick(1);
      oready_a = 1'b1;
      in_a     = 34'h13f800000;
      ivalid_a = 1'b1;
      pbase    = pop_cnt_a;
      tick(1);
      ivalid_a = 1'b0;
      @(negedge clk);
      check("t1_op_x", op_x_a, 34'h13f800000);
      check("t1_op_y", op_y_a, CONST_Y_A);
      for (int g = 0; g < 40 && pop_cnt_a == pbase; g++) tick(1);
      check("t1_popped", pop_cnt_a - pbase, 1);
      check("t1_latency", last_lat_a, LAT_A + 2);
      tick(5);

      // T2: 100 back-to-back items at full rate.
      base = n_acc_a; pbase = pop_cnt_a; t0 = 0;
      ivalid_a = 1'b1;
      in_a     = rnd();
      for (int g = 0; g < 400 && (n_acc_a - base) < 100; g++) begin
         prev = n_acc_a;
         tick(1);
         if (n_acc_a != prev) begin
            in_a = rnd();
            if (n_acc_a - base == 1) t0 = last_acc_a;
         end
      end
      ivalid_a = 1'b0;
      check("t2_accepted", n_acc_a - base, 100);
      check("t2_input_rate", last_acc_a - t0, 99);
      for (int g = 0; g < 100 && (pop_cnt_a - pbase) < 100; g++) tick(1);
      check("t2_popped", pop_cnt_a - pbase, 100);
      check("t2_output_rate", last_pop_a - last_acc_a, LAT_A + 2);

      // T3: downstream stalled from the start; exactly FIFO_DEPTH accepted.
      base = n_acc_a; pbase = pop_cnt_a;
      oready_a = 1'b0;
      ivalid_a = 1'b1;
      for (int g = 0; g < 40; g++) begin
         in_a = rnd();
         tick(1);
      end
      check("t3_accepted", n_acc_a - base, D_A);
      @(negedge clk);
      check("t3_credits_full", credits_a, D_A);
      check("t3_iready_low", iready_a, 1'b0);
      check("t3_ovalid", ovalid_a, 1'b1);
      tick(1);
      drain_a();
      check("t3_drained", pop_cnt_a - pbase, D_A);

      // T6: reset with results both in flight and stored.
      base = n_acc_a;
      oready_a = 1'b0;
      ivalid_a = 1'b1;
      for (int g = 0; g < 40 && (n_acc_a - base) < 11; g++) begin
         in_a = rnd();
         tick(1);
      end
      ivalid_a = 1'b0;
      tick(5);
      @(negedge clk);
      check("t6_pre_ovalid", ovalid_a, 1'b1);
      check("t6_pre_credits", credits_a, 11);
      tick(1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      pbase = pop_cnt_a;
      @(negedge clk);
      check("t6_ovalid_after_rst", ovalid_a, 1'b0);
      check("t6_credits_after_rst", credits_a, 0);
      tick(1);
      oready_a = 1'b1;
      tick(40);
      check("t6_no_stale_output", pop_cnt_a - pbase, 0);

      // T4: stream 1 valid alone for 5 cycles, then both.
      base = n_acc_b;
      oready_b = 1'b1;
      ivalid_b = 2'b10;
      in_b     = {rnd(), rnd()};
      for (int g = 0; g < 5; g++) begin
         @(negedge clk);
         check("t4_iready_wait", iready_b, 2'b01);
         tick(1);
      end
      check("t4_no_partial", n_acc_b - base, 0);
      ivalid_b = 2'b11;
      tick(1);
      ivalid_b = 2'b00;
      check("t4_one_transfer", n_acc_b - base, 1);
      drain_b();

      // Random join/back-pressure traffic on the two-stream node.
      for (int g = 0; g < 300; g++) begin
         ivalid_b = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
         oready_b = ($urandom_range(0, 2) != 0);
         in_b     = {rnd(), rnd()};
         tick(1);
      end
      drain_b();

      // T5: shallow FIFO, saturated input, oready high.
      base = n_acc_b;
      oready_b = 1'b1;
      ivalid_b = 2'b11;
      for (int g = 0; g < 64; g++) begin
         in_b = {rnd(), rnd()};
         tick(1);
      end
      ivalid_b = 2'b00;
      check("t5_rate_in_range",
            ((n_acc_b - base) >= 32) && ((n_acc_b - base) <= 40), 1'b1);
      check("t5_max_credits", max_cred_b <= D_B, 1'b1);
      drain_b();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
